// File: rtl/rr_sel_if.sv
// Select-code bus between the round-robin encoder (master) and a code-driven selector (slave).
interface rr_sel_if #(
    parameter int N_REQ  = 8,
    parameter int CODE_W = 3
);
    logic [N_REQ-1:0]  req_i;
    logic [CODE_W-1:0] code_o;
    logic              valid_o;
    logic              ready_i;
    logic [N_REQ-1:0]  grant_o;
    logic              err_o;

    modport master (
        input  req_i, ready_i,
        output code_o, valid_o, grant_o, err_o
    );

    modport slave (
        output req_i, ready_i,
        input  code_o, valid_o, grant_o, err_o
    );
endinterface

// File: rtl/rr_sel_encoder.sv
// Round-robin arbiter that offers one registered select code per grant on a valid/ready
// handshake, dropping an offer with an error pulse if it waits TIMEOUT cycles unaccepted.
module rr_sel_encoder #(
    parameter int N_REQ   = 8,
    parameter int CODE_W  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic     clk,
    input  logic     rst,
    rr_sel_if.master bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(N_REQ - 1);

    typedef enum logic {S_IDLE, S_OFFER} state_e;

    state_e            state_q;
    logic [CODE_W-1:0] ptr_q;
    logic [CODE_W-1:0] code_q;
    logic [N_REQ-1:0]  grant_q;
    logic              valid_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              pick_found_d;
    logic [CODE_W-1:0] pick_idx_d;
    logic [CODE_W-1:0] ptr_d;
    int                idx;

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        idx          = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!pick_found_d && bus.req_i[idx]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = CODE_W'(idx);
            end
        end
    end

    // Pointer moves just past the requester that was served or dropped.
    assign ptr_d = (code_q == CODE_MAX) ? '0 : code_q + 1'b1;

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            code_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found_d) begin
                        code_q  <= pick_idx_d;
                        grant_q <= N_REQ'(1) << pick_idx_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_OFFER;
                    end else begin
                        code_q  <= '0;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                    end
                end
                S_OFFER: begin
                    if (bus.ready_i) begin
                        code_q  <= '0;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= S_IDLE;
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        code_q  <= '0;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                        ptr_q   <= ptr_d;
                        state_q <= S_IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.code_o  = code_q;
    assign bus.grant_o = grant_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;
endmodule
